// File: rtl/vga_mono_filter.sv
// ---------------------------------------------------------------------------
// vga_mono_filter
//
// Three-stage pixel pipeline that turns a colour VGA stream into one of
// several monochrome renderings (green, amber, white, custom tint, inverted
// white), or passes the colour through untouched.
//
//   S1 : per-channel luma weights (54, 183, 19), mode/gain selection
//   S2 : luma sum with rounding, Y = (54R + 183G + 19B + 128) >> 8
//   S3 : tint multiply / passthrough / inversion, blank forcing
//
// Mode and custom gains change only at the start of a frame: the cycle on
// which vsync_in first reaches its active level. Mode and gains ride along
// the pipeline with each pixel, so a frame is never rendered in two modes.
//
// Ports
//   clk_vga                  pixel clock (only clock)
//   rst                      synchronous, active-high reset
//   r_in/g_in/b_in [CW]      source pixel
//   hsync_in/vsync_in/blank_in  source timing
//   mode_req [3]             0 colour, 1 green, 2 amber, 3 white,
//                            4 custom, 5 inverted white, 6/7 -> colour
//   tint_r/g/b [8]           custom tint gains (latched at frame boundary)
//   r_out/g_out/b_out [CW]   filtered pixel, 3 cycles after input
//   hsync_out/vsync_out/blank_out  timing delayed by 3 cycles
//   mode_active [3]          mode currently applied at S1
//   mode_pending             sanitised mode_req differs from mode_active
// ---------------------------------------------------------------------------
module vga_mono_filter #(
    parameter int CW     = 6,
    parameter bit VS_POL = 1'b0
) (
    input  logic          clk_vga,
    input  logic          rst,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          blank_in,
    input  logic [2:0]    mode_req,
    input  logic [7:0]    tint_r,
    input  logic [7:0]    tint_g,
    input  logic [7:0]    tint_b,
    output logic [CW-1:0] r_out,
    output logic [CW-1:0] g_out,
    output logic [CW-1:0] b_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          blank_out,
    output logic [2:0]    mode_active,
    output logic          mode_pending
);

    localparam int PW = CW + 8;   // one weighted channel
    localparam int SW = CW + 9;   // sum of three weighted channels + rounding

    localparam logic [2:0] M_COLOUR = 3'd0;
    localparam logic [2:0] M_GREEN  = 3'd1;
    localparam logic [2:0] M_AMBER  = 3'd2;
    localparam logic [2:0] M_WHITE  = 3'd3;
    localparam logic [2:0] M_CUSTOM = 3'd4;
    localparam logic [2:0] M_INVERT = 3'd5;

    localparam logic [CW-1:0] PIX_MAX = '1;
    localparam logic [7:0]    LUMA_W [3] = '{8'd54, 8'd183, 8'd19};

    // sync bundle bit positions
    localparam int HS = 0;
    localparam int VS = 1;
    localparam int BK = 2;

    // channel-indexed views of the ports (0 = R, 1 = G, 2 = B)
    logic [CW-1:0] pix_in   [3];
    logic [7:0]    tint_in  [3];

    assign pix_in[0]  = r_in;
    assign pix_in[1]  = g_in;
    assign pix_in[2]  = b_in;
    assign tint_in[0] = tint_r;
    assign tint_in[1] = tint_g;
    assign tint_in[2] = tint_b;

    // control state
    logic          vs_prev_q,     vs_prev_d;
    logic [2:0]    mode_active_q, mode_active_d;
    logic [7:0]    cgain_q [3];
    logic [7:0]    cgain_d [3];

    // S1
    logic [PW-1:0] prod1_q [3];
    logic [PW-1:0] prod1_d [3];
    logic [CW-1:0] pix1_q  [3];
    logic [CW-1:0] pix1_d  [3];
    logic [7:0]    gain1_q [3];
    logic [7:0]    gain1_d [3];
    logic [2:0]    mode1_q, mode1_d;
    logic [2:0]    sync1_q, sync1_d;

    // S2
    logic [CW-1:0] y2_q,    y2_d;
    logic [CW-1:0] pix2_q  [3];
    logic [CW-1:0] pix2_d  [3];
    logic [7:0]    gain2_q [3];
    logic [7:0]    gain2_d [3];
    logic [2:0]    mode2_q, mode2_d;
    logic [2:0]    sync2_q, sync2_d;

    // S3 (output registers)
    logic [CW-1:0] out3_q  [3];
    logic [CW-1:0] out3_d  [3];
    logic [2:0]    sync3_q, sync3_d;

    // per-channel arithmetic
    logic [PW-1:0] luma_prod  [3];
    logic [CW-1:0] tint_shift [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign luma_prod[gi] = PW'(pix_in[gi]) * PW'(LUMA_W[gi]);
            // (Y * (gain + 1)) >> 8 never exceeds Y, so CW bits suffice
            assign tint_shift[gi] =
                CW'((PW'(y2_q) * (PW'(gain2_q[gi]) + PW'(1))) >> 8);
        end
    endgenerate

    logic [2:0] mode_req_s;
    logic       frame_edge;

    always_comb begin
        mode_req_s = (mode_req > M_INVERT) ? M_COLOUR : mode_req;
        // vs_prev_q resets to 0, so with VS_POL = 1 a high vsync right after
        // reset is treated as a fresh frame boundary
        frame_edge = (vsync_in == VS_POL) && (vs_prev_q != VS_POL);

        vs_prev_d     = vsync_in;
        mode_active_d = frame_edge ? mode_req_s : mode_active_q;
        for (int i = 0; i < 3; i++) begin
            cgain_d[i] = frame_edge ? tint_in[i] : cgain_q[i];
        end

        // S1: weights and gain selection from the mode in force now
        mode1_d = mode_active_q;
        sync1_d = {blank_in, vsync_in, hsync_in};
        for (int i = 0; i < 3; i++) begin
            prod1_d[i] = luma_prod[i];
            pix1_d[i]  = pix_in[i];
            gain1_d[i] = 8'd0;
        end
        case (mode_active_q)
            M_GREEN: begin
                gain1_d[1] = 8'd255;
            end
            M_AMBER: begin
                gain1_d[0] = 8'd255;
                gain1_d[1] = 8'd127;
            end
            M_WHITE: begin
                gain1_d[0] = 8'd255;
                gain1_d[1] = 8'd255;
                gain1_d[2] = 8'd255;
            end
            M_CUSTOM: begin
                for (int i = 0; i < 3; i++) gain1_d[i] = cgain_q[i];
            end
            default: ;
        endcase

        // S2: rounded luma sum
        y2_d    = CW'((SW'(prod1_q[0]) + SW'(prod1_q[1]) + SW'(prod1_q[2])
                       + SW'(128)) >> 8);
        mode2_d = mode1_q;
        sync2_d = sync1_q;
        for (int i = 0; i < 3; i++) begin
            pix2_d[i]  = pix1_q[i];
            gain2_d[i] = gain1_q[i];
        end

        // S3: final rendering, blank wins over everything
        sync3_d = sync2_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[BK]) begin
                out3_d[i] = '0;
            end else if (mode2_q == M_COLOUR) begin
                out3_d[i] = pix2_q[i];
            end else if (mode2_q == M_INVERT) begin
                out3_d[i] = PIX_MAX - y2_q;
            end else begin
                out3_d[i] = tint_shift[i];
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            vs_prev_q     <= 1'b0;
            mode_active_q <= M_COLOUR;
            mode1_q       <= '0;
            sync1_q       <= '0;
            y2_q          <= '0;
            mode2_q       <= '0;
            sync2_q       <= '0;
            sync3_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                cgain_q[i] <= 8'd255;
                prod1_q[i] <= '0;
                pix1_q[i]  <= '0;
                gain1_q[i] <= '0;
                pix2_q[i]  <= '0;
                gain2_q[i] <= '0;
                out3_q[i]  <= '0;
            end
        end else begin
            vs_prev_q     <= vs_prev_d;
            mode_active_q <= mode_active_d;
            mode1_q       <= mode1_d;
            sync1_q       <= sync1_d;
            y2_q          <= y2_d;
            mode2_q       <= mode2_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            for (int i = 0; i < 3; i++) begin
                cgain_q[i] <= cgain_d[i];
                prod1_q[i] <= prod1_d[i];
                pix1_q[i]  <= pix1_d[i];
                gain1_q[i] <= gain1_d[i];
                pix2_q[i]  <= pix2_d[i];
                gain2_q[i] <= gain2_d[i];
                out3_q[i]  <= out3_d[i];
            end
        end
    end

    assign r_out        = out3_q[0];
    assign g_out        = out3_q[1];
    assign b_out        = out3_q[2];
    assign hsync_out    = sync3_q[HS];
    assign vsync_out    = sync3_q[VS];
    assign blank_out    = sync3_q[BK];
    assign mode_active  = mode_active_q;
    assign mode_pending = (mode_req_s != mode_active_q);

endmodule
